// File: rtl/mac_arb_pkg.sv
// Shared constants and helpers for the 3x3 MAC window arbiter.
// Window geometry, id width and packed-bus slicing used by the top and the MAC pipe.
package mac_arb_pkg;

    localparam int KERN_TAPS = 9;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int win_w(input int data_w);
        return KERN_TAPS * data_w;
    endfunction

    // LSB of requester k's window inside a packed NUM_REQ*WIN_W request bus
    function automatic int win_lsb(input int k, input int data_w);
        return k * KERN_TAPS * data_w;
    endfunction

endpackage

// File: rtl/mac9_pipe.sv
// Nine unsigned-pixel x signed-tap products, summed and held in the S1 result register.
// With MAC_ARB_RELU_EN defined the stored result is clamped at zero from below.
module mac9_pipe
    import mac_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int ID_W   = 2,
    localparam int WIN_W  = win_w(DATA_W),
    localparam int PROD_W = 2 * DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              vld_in,
    input  logic [WIN_W-1:0]  pix,
    input  logic [WIN_W-1:0]  kern,
    input  logic [ID_W-1:0]   id_in,
    output logic              vld_out,
    output logic [ACC_W-1:0]  data_out,
    output logic [ID_W-1:0]   id_out
);

    logic signed [PROD_W-1:0] px   [KERN_TAPS];
    logic signed [PROD_W-1:0] kx   [KERN_TAPS];
    logic signed [PROD_W-1:0] prod [KERN_TAPS];
    logic signed [ACC_W-1:0]  sum;

    function automatic logic signed [ACC_W-1:0] shape_result(input logic signed [ACC_W-1:0] x);
`ifdef MAC_ARB_RELU_EN
        return x[ACC_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    always_comb begin
        sum = '0;
        for (int t = 0; t < KERN_TAPS; t++) begin
            px[t]   = PROD_W'($signed({1'b0, pix[t*DATA_W +: DATA_W]}));
            kx[t]   = PROD_W'($signed(kern[t*DATA_W +: DATA_W]));
            prod[t] = px[t] * kx[t];
            sum     = sum + ACC_W'(prod[t]);
        end
    end

    // S1: result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_out  <= 1'b0;
            data_out <= '0;
            id_out   <= '0;
        end else if (en) begin
            vld_out <= vld_in;
            if (vld_in) begin
                data_out <= shape_result(sum);
                id_out   <= id_in;
            end
        end
    end

endmodule

// File: rtl/mac_window_arbiter.sv
// Round-robin arbiter sharing one two-stage 3x3 MAC among NUM_REQ window requesters.
// Optional MAC_ARB_RELU_EN clamps results at zero; handshake and latency are unchanged.
module mac_window_arbiter
    import mac_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20,
    localparam int ID_W   = id_width(NUM_REQ),
    localparam int WIN_W  = win_w(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIN_W-1:0] req_pixel,
    input  logic [NUM_REQ*WIN_W-1:0] req_kernel,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_W-1:0]         res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy
);

    logic              adv;
    logic              accept;
    logic              cand_found;
    logic [ID_W-1:0]   cand_id;
    logic [ID_W-1:0]   ptr;
    logic              vld_p0;
    logic [WIN_W-1:0]  pix_p0;
    logic [WIN_W-1:0]  kern_p0;
    logic [ID_W-1:0]   id_p0;
    logic              vld_p1;

    function automatic int scan_idx(input logic [ID_W-1:0] p, input int i);
        return (int'(p) + i) % NUM_REQ;
    endfunction

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    assign adv    = !vld_p1 || res_ready;
    assign accept = cand_found && adv && !rst;

    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!cand_found && req_valid[scan_idx(ptr, i)]) begin
                cand_found = 1'b1;
                cand_id    = ID_W'(scan_idx(ptr, i));
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[cand_id] = 1'b1;
    end

    // S0: operand register (control)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= accept;
            if (accept) ptr <= wrap_inc(cand_id);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix_p0  <= req_pixel[win_lsb(int'(cand_id), DATA_W) +: WIN_W];
            kern_p0 <= req_kernel[win_lsb(int'(cand_id), DATA_W) +: WIN_W];
            id_p0   <= cand_id;
        end
    end

    mac9_pipe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .ID_W   (ID_W)
    ) u_mac9_pipe (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .vld_in   (vld_p0),
        .pix      (pix_p0),
        .kern     (kern_p0),
        .id_in    (id_p0),
        .vld_out  (vld_p1),
        .data_out (res_data),
        .id_out   (res_id)
    );

    assign res_valid = vld_p1;
    assign busy      = vld_p0 | vld_p1;

endmodule

// File: tb/tb_mac_window_arbiter.sv
// Directed bench for mac_window_arbiter: grants, arithmetic, streaming, stalls and reset.
module tb_mac_window_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 20;
    localparam int ID_W    = 2;
    localparam int WIN_W   = 9 * DATA_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIN_W-1:0] req_pixel;
    logic [NUM_REQ*WIN_W-1:0] req_kernel;
    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_W-1:0]         res_data;
    logic [ID_W-1:0]          res_id;
    logic                     busy;

    int checks = 0;
    int errors = 0;
    int exp_id;
    int hold_id;

    mac_window_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pixel  (req_pixel),
        .req_kernel (req_kernel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int relu_ref(input int v);
`ifdef MAC_ARB_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk_res(input string tag, input int id, input int val);
        logic [ACC_W-1:0] e;
        e = ACC_W'(relu_ref(val));
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_id"},    32'(res_id),    32'(id));
        chk({tag, "_data"},  32'(res_data),  32'(e));
    endtask

    task automatic set_req(input int k, input logic [7:0] pix, input logic [7:0] kern);
        for (int t = 0; t < 9; t++) begin
            req_pixel[(k*9+t)*DATA_W +: DATA_W]  = pix;
            req_kernel[(k*9+t)*DATA_W +: DATA_W] = kern;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_pixel  = '0;
        req_kernel = '0;
        res_ready  = 1'b1;
        tick();
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        rst = 1'b0;

        // single requester 1: 9 * 1 * 2 = 18, two edges after accept
        set_req(1, 8'd1, 8'd2);
        req_valid = 4'b0010;
        #1;
        chk("single_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_not_yet", 32'(res_valid), 32'd0);
        tick();
        chk_res("single", 1, 18);

        // ptr = 2, requesters 1 and 3: 3 first (9*3*-1 = -27), then 1 (9*2*3 = 54)
        set_req(1, 8'd2, 8'd3);
        set_req(3, 8'd3, 8'hFF);
        req_valid = 4'b1010;
        #1;
        chk("rr_first", 32'(req_ready), 32'h8);
        tick();
        req_valid[3] = 1'b0;
        #1;
        chk("rr_second", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk_res("rr3", 3, -27);
        tick();
        chk_res("rr1", 1, 54);
        tick();
        chk("rr_drained", 32'(res_valid), 32'd0);

        // ptr = 2, worst negative: 9 * 255 * -128 = -293760
        set_req(2, 8'd255, 8'h80);
        req_valid = 4'b0100;
        #1;
        chk("neg_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        chk_res("neg", 2, -293760);

        // reset while busy (ptr = 3)
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 8'(k + 1), 8'd1);
        req_valid = 4'b1111;
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(res_valid), 32'd0);
        chk("async_rst_busy",  32'(busy),      32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rst_hold_valid", 32'(res_valid), 32'd0);
        chk("rst_hold_busy",  32'(busy),      32'd0);
        chk("rst_hold_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h1);

        // full-rate stream: ids 0,1,2,3,0,... with data 9*(id+1)
        tick();
        chk("stream_fill", 32'(res_valid), 32'd0);
        exp_id = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk_res("stream", exp_id, 9 * (exp_id + 1));
            exp_id = (exp_id + 1) % NUM_REQ;
        end

        // stall 5 cycles: output held, no grants
        hold_id   = (exp_id + NUM_REQ - 1) % NUM_REQ;
        res_ready = 1'b0;
        #1;
        chk("stall_ready", 32'(req_ready), 32'd0);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk_res("stall", hold_id, 9 * (hold_id + 1));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk_res("resume", exp_id, 9 * (exp_id + 1));
            exp_id = (exp_id + 1) % NUM_REQ;
        end

        req_valid = '0;
        tick();
        tick();
        tick();
        chk("drain_valid", 32'(res_valid), 32'd0);
        chk("drain_busy",  32'(busy),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
